// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Fetch PC, in-order imem requests and a PC-tagged instruction FIFO
//            for decode, with redirect flush and discard of stale responses.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        RedirectValid,
    input  logic [63:0] RedirectPC,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [63:0] ImemReqAddr,
    input  logic        ImemRespValid,
    input  logic [31:0] ImemRespData,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Inst,
    output logic [63:0] InstPC
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_OW = $clog2(MAX_OUT + 1);
    localparam int c_TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int c_SW = c_CW + 1;

    logic [63:0]     r_pc;
    logic [31:0]     r_data [DEPTH];
    logic [63:0]     r_ipc  [DEPTH];
    logic [c_AW-1:0] r_wr;
    logic [c_AW-1:0] r_rd;
    logic [c_CW-1:0] r_count;
    logic [c_OW-1:0] r_outstanding;
    logic [c_OW-1:0] r_discard;
    logic [63:0]     r_tag  [MAX_OUT];
    logic [c_TW-1:0] r_tag_wr;
    logic [c_TW-1:0] r_tag_rd;

    logic            w_acc;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic [c_SW-1:0] w_credit;
    logic [c_OW-1:0] w_out_next;

    // Slots already reserved by live requests count against FIFO space.
    assign w_credit = c_SW'(r_count) + c_SW'(r_outstanding) - c_SW'(r_discard);

    assign ImemReqValid = !Reset && !RedirectValid
                          && (r_outstanding < c_OW'(MAX_OUT))
                          && (w_credit < c_SW'(DEPTH));
    assign ImemReqAddr  = Reset ? 64'h0 : r_pc;
    assign InstValid    = !Reset && (r_count != '0);
    assign Inst         = Reset ? 32'h0 : r_data[r_rd];
    assign InstPC       = Reset ? 64'h0 : r_ipc[r_rd];

    assign w_acc      = ImemReqValid && ImemReqReady;
    assign w_resp     = !Reset && ImemRespValid && (r_outstanding != '0);
    assign w_push     = w_resp && (r_discard == '0) && !RedirectValid;
    assign w_pop      = InstValid && InstReady;
    assign w_out_next = r_outstanding + c_OW'(w_acc) - c_OW'(w_resp);

    function automatic logic [c_TW-1:0] tag_inc(input logic [c_TW-1:0] p);
        tag_inc = (p == c_TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc          <= RESET_PC;
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_acc) begin
                r_tag_wr <= tag_inc(r_tag_wr);
            end
            if (w_resp) begin
                r_tag_rd <= tag_inc(r_tag_rd);
            end
            if (RedirectValid) begin
                r_pc      <= {RedirectPC[63:2], 2'b00};
                r_wr      <= '0;
                r_rd      <= '0;
                r_count   <= '0;
                r_discard <= w_out_next;
            end else begin
                if (w_acc) begin
                    r_pc <= r_pc + 64'd4;
                end
                if (w_resp && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_push) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    // Storage arrays need no reset; validity is tracked by pointers and counts.
    always_ff @(posedge Clk) begin
        if (w_acc) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_data[r_wr] <= ImemRespData;
            r_ipc[r_wr]  <= r_tag[r_tag_rd];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (!(w_push && !w_pop && (r_count == c_CW'(DEPTH))));
            assert (!(ImemRespValid && (r_outstanding == '0)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Directed self-checking bench for instr_fetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    logic        Clk;
    logic        Reset;
    logic        RedirectValid;
    logic [63:0] RedirectPC;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [63:0] ImemReqAddr;
    logic        ImemRespValid;
    logic [31:0] ImemRespData;
    logic        InstValid;
    logic        InstReady;
    logic [31:0] Inst;
    logic [63:0] InstPC;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mem_auto;
    logic [63:0] mq[$];

    instr_fetch_queue #(
        .DEPTH   (4),
        .MAX_OUT (2),
        .RESET_PC(64'h0)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .RedirectValid(RedirectValid),
        .RedirectPC   (RedirectPC),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemReqAddr  (ImemReqAddr),
        .ImemRespValid(ImemRespValid),
        .ImemRespData (ImemRespData),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .Inst         (Inst),
        .InstPC       (InstPC)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] memword(input logic [63:0] a);
        memword = a[31:0] ^ 32'hCAFE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Ends one cycle; the 1-cycle memory model answers the next cycle.
    task automatic tick();
        if (ImemReqValid && ImemReqReady) mq.push_back(ImemReqAddr);
        @(posedge Clk);
        @(negedge Clk);
        if (mem_auto) begin
            if (mq.size() > 0) begin
                ImemRespValid = 1'b1;
                ImemRespData  = memword(mq.pop_front());
            end else begin
                ImemRespValid = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        RedirectValid = 1'b0;
        ImemRespValid = 1'b0;
        mq.delete();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("rst_reqv", ImemReqValid, 1'b0);
            check("rst_iv", InstValid, 1'b0);
            tick();
        end
        Reset         = 1'b0;
        ImemRespValid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; RedirectValid = 1'b0; RedirectPC = '0;
        ImemReqReady = 1'b1; ImemRespValid = 1'b0; ImemRespData = '0;
        InstReady = 1'b1; mem_auto = 1'b1;
        @(negedge Clk);

        // streaming fetch
        do_reset();
        mem_auto = 1'b1; InstReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("t1_reqv", ImemReqValid, 1'b1);
            check("t1_addr", ImemReqAddr, 64'(4 * k));
            if (k >= 2) begin
                check("t1_iv", InstValid, 1'b1);
                check("t1_ipc", InstPC, 64'(4 * (k - 2)));
                check("t1_inst", Inst, memword(64'(4 * (k - 2))));
            end else begin
                check("t1_iv0", InstValid, 1'b0);
            end
            tick();
        end

        // back-pressure fills exactly DEPTH entries
        do_reset();
        InstReady = 1'b0;
        for (int k = 0; k < 8; k++) begin
            settle();
            check("t2_reqv", ImemReqValid, (k < 4) ? 1'b1 : 1'b0);
            if (k < 4) check("t2_addr", ImemReqAddr, 64'(4 * k));
            if (k >= 2) check("t2_head", InstPC, 64'h0);
            tick();
        end
        InstReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            check("t2_iv", InstValid, 1'b1);
            check("t2_ipc", InstPC, 64'(4 * k));
            if (k == 0) check("t2_full_reqv", ImemReqValid, 1'b0);
            if (k == 1) begin
                check("t2_resume_reqv", ImemReqValid, 1'b1);
                check("t2_resume_addr", ImemReqAddr, 64'h10);
            end
            tick();
        end

        // redirect with two requests in flight
        do_reset();
        mem_auto = 1'b0; InstReady = 1'b1;
        RedirectValid = 1'b1; RedirectPC = 64'h10;
        settle(); check("t3_redir_noreq", ImemReqValid, 1'b0); tick();
        RedirectValid = 1'b0;
        settle(); check("t3_addr10", ImemReqAddr, 64'h10); check("t3_reqv10", ImemReqValid, 1'b1); tick();
        settle(); check("t3_addr14", ImemReqAddr, 64'h14); check("t3_reqv14", ImemReqValid, 1'b1); tick();
        RedirectValid = 1'b1; RedirectPC = 64'h203;
        settle(); check("t3_redir_noreq2", ImemReqValid, 1'b0); tick();
        RedirectValid = 1'b0;
        ImemRespValid = 1'b1; ImemRespData = 32'hDEAD_0010;
        settle();
        check("t3_addr200", ImemReqAddr, 64'h200);
        check("t3_maxout", ImemReqValid, 1'b0);
        check("t3_iv_a", InstValid, 1'b0);
        tick();
        ImemRespData = 32'hDEAD_0014;
        settle();
        check("t3_reqv200", ImemReqValid, 1'b1);
        check("t3_addr200b", ImemReqAddr, 64'h200);
        check("t3_iv_b", InstValid, 1'b0);
        tick();
        ImemRespData = 32'h1234_5678;
        settle(); check("t3_iv_c", InstValid, 1'b0); tick();
        ImemRespValid = 1'b0;
        settle();
        check("t3_iv", InstValid, 1'b1);
        check("t3_ipc", InstPC, 64'h200);
        check("t3_inst", Inst, 32'h1234_5678);
        tick();

        // redirect coinciding with a response; one more still in flight
        do_reset();
        RedirectValid = 1'b1; RedirectPC = 64'h1C;
        settle(); tick();
        RedirectValid = 1'b0;
        settle(); check("t4_addr1c", ImemReqAddr, 64'h1C); check("t4_reqv1c", ImemReqValid, 1'b1); tick();
        settle(); check("t4_addr20", ImemReqAddr, 64'h20); check("t4_reqv20", ImemReqValid, 1'b1); tick();
        RedirectValid = 1'b1; RedirectPC = 64'h40;
        ImemRespValid = 1'b1; ImemRespData = 32'hBAD0_001C;
        settle(); check("t4_redir_noreq", ImemReqValid, 1'b0); tick();
        RedirectValid = 1'b0;
        ImemRespData = 32'hBAD0_0020;
        settle();
        check("t4_reqv40", ImemReqValid, 1'b1);
        check("t4_addr40", ImemReqAddr, 64'h40);
        check("t4_iv_a", InstValid, 1'b0);
        tick();
        ImemRespData = 32'h4040_4040;
        settle(); check("t4_iv_b", InstValid, 1'b0); tick();
        ImemRespValid = 1'b0;
        settle();
        check("t4_iv", InstValid, 1'b1);
        check("t4_ipc", InstPC, 64'h40);
        check("t4_inst", Inst, 32'h4040_4040);
        tick();

        // PC wrap at 2^64
        do_reset();
        mem_auto = 1'b1;
        RedirectValid = 1'b1; RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
        settle(); tick();
        RedirectValid = 1'b0;
        settle(); check("t5_addr_top", ImemReqAddr, 64'hFFFF_FFFF_FFFF_FFFC); check("t5_reqv", ImemReqValid, 1'b1); tick();
        settle(); check("t5_addr_wrap", ImemReqAddr, 64'h0); check("t5_iv0", InstValid, 1'b0); tick();
        settle(); check("t5_ipc_top", InstPC, 64'hFFFF_FFFF_FFFF_FFFC); check("t5_iv_a", InstValid, 1'b1); tick();
        settle(); check("t5_ipc_wrap", InstPC, 64'h0); check("t5_iv_b", InstValid, 1'b1); tick();

        // reset mid-operation with buffered words and two outstanding
        do_reset();
        mem_auto = 1'b0; InstReady = 1'b0;
        settle(); check("t6_addr0", ImemReqAddr, 64'h0); tick();
        settle(); check("t6_addr4", ImemReqAddr, 64'h4); tick();
        ImemRespValid = 1'b1; ImemRespData = 32'h0000_AAAA;
        settle(); check("t6_maxout", ImemReqValid, 1'b0); tick();
        ImemRespData = 32'h0000_BBBB;
        settle(); check("t6_reqv8", ImemReqValid, 1'b1); check("t6_addr8", ImemReqAddr, 64'h8); tick();
        ImemRespValid = 1'b0;
        settle();
        check("t6_addrc", ImemReqAddr, 64'hC);
        check("t6_iv_pre", InstValid, 1'b1);
        check("t6_ipc_pre", InstPC, 64'h0);
        tick();
        Reset = 1'b1; ImemRespValid = 1'b1; ImemRespData = 32'h0000_CCCC;
        settle();
        check("t6_rst_iv", InstValid, 1'b0);
        check("t6_rst_reqv", ImemReqValid, 1'b0);
        check("t6_rst_addr", ImemReqAddr, 64'h0);
        check("t6_rst_inst", Inst, 32'h0);
        check("t6_rst_ipc", InstPC, 64'h0);
        tick();
        Reset = 1'b0; ImemRespValid = 1'b0;
        settle();
        check("t6_post_iv", InstValid, 1'b0);
        check("t6_post_reqv", ImemReqValid, 1'b1);
        check("t6_post_addr", ImemReqAddr, 64'h0);
        tick();
        settle(); check("t6_post_iv2", InstValid, 1'b0); tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
